// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data memory.
// Each access gets a one-cycle memory slot, then a registered response.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic StIdle   = 1'b0;
  localparam logic StAccess = 1'b1;
  localparam logic [31:0] LimitBytes = 32'(4 * DEPTH_WORDS);

  logic        state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        active;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        bad;
  logic [31:0] resp_data;

  assign active    = (state_q == StAccess);
  assign sel_we    = owner_q ? p1_we    : p0_we;
  assign sel_addr  = owner_q ? p1_addr  : p0_addr;
  assign sel_wdata = owner_q ? p1_wdata : p0_wdata;
  assign bad       = (sel_addr[1:0] != 2'b00) || (sel_addr >= LimitBytes);

  // Gated on registered state so a reset mid-slot drops mem_we at once.
  assign mem_we    = active && sel_we && !bad;
  assign mem_addr  = active ? sel_addr  : 32'd0;
  assign mem_wdata = active ? sel_wdata : 32'd0;

  assign p0_gnt    = active && !owner_q;
  assign p1_gnt    = active && owner_q;
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

  assign resp_data = (!sel_we && !bad) ? mem_rdata : 32'd0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rvalid_d = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (state_q == StIdle) begin
      if (p0_req && p1_req) begin
        owner_d = ~last_q;
        state_d = StAccess;
      end else if (p0_req || p1_req) begin
        owner_d = p1_req;
        state_d = StAccess;
      end
    end else begin
      state_d = StIdle;
      last_d  = owner_q;
      if (owner_q) begin
        rvalid_d = 2'b10;
        err_d    = {bad, 1'b0};
        rdata1_d = resp_data;
      end else begin
        rvalid_d = 2'b01;
        err_d    = {1'b0, bad};
        rdata0_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level reference model with its own shadow memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v [2];
  logic        we_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int          slot;
  int          last;
  logic        exp_rvalid [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];
  int          gnt_cnt [2];
  int          rv_cnt [2];
  logic        hold [2];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (req_v[0]),
    .p0_we     (we_v[0]),
    .p0_addr   (addr_v[0]),
    .p0_wdata  (wdata_v[0]),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (req_v[1]),
    .p1_we     (we_v[1]),
    .p1_addr   (addr_v[1]),
    .p1_wdata  (wdata_v[1]),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory array the DUT drives: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 256);
  endfunction

  task automatic model_reset();
    slot = -1;
    last = 1;
    for (int k = 0; k < 2; k++) begin
      exp_rvalid[k] = 1'b0;
      exp_err[k]    = 1'b0;
      exp_rdata[k]  = 32'd0;
    end
  endtask

  // Advance the reference by one clock edge using the inputs held during the last cycle.
  task automatic model_edge();
    int k;
    int idx;
    logic b;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_rvalid[0] = 1'b0;
    exp_rvalid[1] = 1'b0;
    exp_err[0]    = 1'b0;
    exp_err[1]    = 1'b0;
    if (slot >= 0) begin
      k   = slot;
      b   = is_bad(addr_v[k]);
      idx = int'(addr_v[k] / 4) % 64;
      exp_rvalid[k] = 1'b1;
      exp_err[k]    = b;
      exp_rdata[k]  = (b || we_v[k]) ? 32'd0 : ref_mem[idx];
      if (!b && we_v[k]) ref_mem[idx] = wdata_v[k];
      last = k;
      slot = -1;
    end else if (req_v[0] && req_v[1]) begin
      slot = 1 - last;
    end else if (req_v[0]) begin
      slot = 0;
    end else if (req_v[1]) begin
      slot = 1;
    end
  endtask

  task automatic compare_all();
    logic        ewe;
    logic [31:0] ea, ed;
    ewe = 1'b0;
    ea  = 32'd0;
    ed  = 32'd0;
    if (slot >= 0) begin
      ewe = we_v[slot] && !is_bad(addr_v[slot]);
      ea  = addr_v[slot];
      ed  = wdata_v[slot];
    end
    check_eq("p0_gnt", {31'd0, p0_gnt}, {31'd0, slot == 0});
    check_eq("p1_gnt", {31'd0, p1_gnt}, {31'd0, slot == 1});
    check_eq("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, exp_rvalid[0]});
    check_eq("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, exp_rvalid[1]});
    check_eq("p0_err", {31'd0, p0_err}, {31'd0, exp_err[0]});
    check_eq("p1_err", {31'd0, p1_err}, {31'd0, exp_err[1]});
    check_eq("p0_rdata", p0_rdata, exp_rdata[0]);
    check_eq("p1_rdata", p1_rdata, exp_rdata[1]);
    check_eq("mem_we", {31'd0, mem_we}, {31'd0, ewe});
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
    if (p0_gnt) gnt_cnt[0]++;
    if (p1_gnt) gnt_cnt[1]++;
    if (p0_rvalid) rv_cnt[0]++;
    if (p1_rvalid) rv_cnt[1]++;
  endtask

  // Present one access, wait for its grant, then drop req after the response cycle.
  task automatic do_access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_v[k]   = 1'b1;
    we_v[k]    = w;
    addr_v[k]  = a;
    wdata_v[k] = d;
    n = 0;
    do begin
      step();
      n++;
    end while (slot != k && n < 8);
    if (slot != k) check_eq("gnt_timeout", 32'd0, 32'd1);
    step();
    req_v[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 63)) * 4;
    if (r == 7) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
    if (r == 8) return 32'($urandom_range(256, 1000));
    return 32'hFFFF_FFFC;
  endfunction

  task automatic new_req(input int k);
    req_v[k]   = 1'b1;
    we_v[k]    = 1'($urandom_range(0, 1));
    addr_v[k]  = rand_addr();
    wdata_v[k] = $urandom;
  endtask

  initial begin
    int g0, r0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h11 * 32'(i + 1);
      ref_mem[i] = 32'h11 * 32'(i + 1);
    end
    for (int k = 0; k < 2; k++) begin
      gnt_cnt[k] = 0;
      rv_cnt[k]  = 0;
      hold[k]    = 1'b0;
    end
    model_reset();

    // Reset held with both ports requesting reads of 0x00 and 0x04.
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h00; wdata_v[0] = 32'd0;
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h04; wdata_v[1] = 32'd0;
    repeat (3) step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check_eq("first_tie_p0", {31'd0, p0_gnt}, 32'd1);
    step();
    step();
    check_eq("then_p1", {31'd0, p1_gnt}, 32'd1);
    step();
    check_eq("p1_rdata_0x22", p1_rdata, 32'h22);
    repeat (8) step();
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    step();
    check_eq("p0_rdata_0x11", p0_rdata, 32'h11);

    do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    do_access(0, 1'b0, 32'h10, 32'd0);
    check_eq("rd_back", p0_rdata, 32'hDEAD_BEEF);

    do_access(1, 1'b1, 32'h102, 32'hFFFF_FFFF);
    do_access(1, 1'b1, 32'h100, 32'hFFFF_FFFF);
    do_access(1, 1'b0, 32'hFC, 32'd0);
    check_eq("fc_unchanged", p1_rdata, 32'h11 * 32'd64);

    // Abort a port 0 write in its memory slot.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hCAFE_F00D;
    for (int n = 0; n < 8 && slot != 0; n++) step();
    check_eq("abort_slot", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_we_drop", {31'd0, mem_we}, 32'd0);
    check_eq("abort_gnt_drop", {31'd0, p0_gnt}, 32'd0);
    model_reset();
    req_v[0] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    r0 = rv_cnt[0];
    repeat (4) step();
    check_eq("abort_word", mem[8], 32'h99);
    check_eq("abort_no_rvalid", 32'(rv_cnt[0] - r0), 32'd0);

    // Port 1 streams four reads with req held throughout.
    g0 = gnt_cnt[1];
    r0 = rv_cnt[1];
    req_v[1] = 1'b1; we_v[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      addr_v[1] = 32'(n * 4 + 64);
      for (int t = 0; t < 8 && slot != 1; t++) step();
      step();
    end
    req_v[1] = 1'b0;
    step();
    check_eq("stream_gnts", 32'(gnt_cnt[1] - g0), 32'd4);
    check_eq("stream_rvalids", 32'(rv_cnt[1] - r0), 32'd4);

    // Random traffic from both ports.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (hold[k]) begin
          hold[k] = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req(k);
          else req_v[k] = 1'b0;
        end else if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          new_req(k);
        end
      end
      for (int k = 0; k < 2; k++) if (slot == k) hold[k] = 1'b1;
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 64; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
